rect_writer: RTL and testbench

RECT_WRITER -- requirements
Module: rect_writer

---
 rtl/rect_writer.sv | 198 +++++++++++++++++++
 tb/tb_rect_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_writer.sv
// Rectangle / pixel writer for an 8-bit-per-pixel framebuffer behind a 32-bit memory port.
// Clears the screen after reset, then services pixel and clipped-rectangle fill requests.
module rect_writer #(
    parameter int unsigned SCREEN_W   = 256,
    parameter int unsigned SCREEN_H   = 192,
    parameter int unsigned MAX_BURST  = 32,
    parameter logic [13:0] GFX_PREFIX = 14'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calib_done,
    output logic        clear_done,
    output logic        ready,
    input  logic        req_en,
    input  logic        req_fill,
    input  logic [7:0]  req_rgb,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [7:0]  req_w,
    input  logic [7:0]  req_h,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_full
);

    localparam int unsigned COORD_W = 8;
    localparam int unsigned WORD_W  = 6;
    localparam int unsigned SUM_W   = COORD_W + 1;

    localparam logic [SUM_W-1:0]  X_MAX  = SUM_W'(SCREEN_W - 1);
    localparam logic [SUM_W-1:0]  Y_MAX  = SUM_W'(SCREEN_H - 1);
    localparam logic [WORD_W-1:0] BL_MAX = WORD_W'(MAX_BURST - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_INIT,
        WR_DATA,
        WR_CMD,
        NEXT
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        rgb_q;
    logic [WORD_W-1:0] first_w, last_w, cur_w, burst_w;
    logic [1:0]        x0_lane, x1_lane;
    logic [COORD_W-1:0] y_cur, y_last;
    logic              clearing;

    logic [SUM_W-1:0]   x_sum_c, y_sum_c;
    logic [COORD_W-1:0] x1_c, y1_c;
    logic               off_screen_c, accept_c;
    logic               row_done_c, last_row_c, burst_end_c;
    logic [3:0]         lo_mask_c, hi_mask_c;

    // Clipped far corner of the incoming request; 9-bit sums cannot wrap.
    always_comb begin
        x_sum_c      = {1'b0, req_x} + (req_fill ? {1'b0, req_w} : SUM_W'(0));
        y_sum_c      = {1'b0, req_y} + (req_fill ? {1'b0, req_h} : SUM_W'(0));
        x1_c         = (x_sum_c > X_MAX) ? X_MAX[COORD_W-1:0] : x_sum_c[COORD_W-1:0];
        y1_c         = (y_sum_c > Y_MAX) ? Y_MAX[COORD_W-1:0] : y_sum_c[COORD_W-1:0];
        off_screen_c = ({1'b0, req_x} > X_MAX) || ({1'b0, req_y} > Y_MAX);
    end

    assign accept_c    = req_en && ready;
    assign row_done_c  = (cur_w == last_w);
    assign last_row_c  = (y_cur == y_last);
    assign burst_end_c = row_done_c || (WORD_W'(cur_w - burst_w) == BL_MAX);

    // Edge masks: bytes left of the start lane on the first word, right of the end lane on the last.
    assign lo_mask_c = (4'b0001 << x0_lane) - 4'b0001;
    assign hi_mask_c = 4'b1110 << x1_lane;

    assign ready             = (state == IDLE) && clear_done && calib_done;
    assign mem_wr_en         = (state == WR_DATA) && calib_done && !mem_wr_full;
    assign mem_cmd_en        = (state == WR_CMD) && calib_done && !mem_cmd_full;
    assign mem_cmd_instr     = 3'b000;
    assign mem_cmd_bl        = WORD_W'(cur_w - burst_w);
    assign mem_cmd_byte_addr = {GFX_PREFIX, y_cur, burst_w, 2'b00};
    assign mem_wr_data       = {4{rgb_q}};
    assign mem_wr_mask       = ((cur_w == first_w) ? lo_mask_c : 4'b0000)
                             | ((cur_w == last_w)  ? hi_mask_c : 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Every transition is gated by calib_done so a calibration drop freezes progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c && !off_screen_c) begin
                    state_nxt = WR_DATA;
                end
            end
            CLEAR_INIT: begin
                if (calib_done) begin
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (mem_wr_en && burst_end_c) begin
                    state_nxt = WR_CMD;
                end
            end
            WR_CMD: begin
                if (mem_cmd_en) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (calib_done) begin
                    state_nxt = (!row_done_c || !last_row_c) ? WR_DATA : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q      <= 8'h00;
            first_w    <= '0;
            last_w     <= '0;
            cur_w      <= '0;
            burst_w    <= '0;
            x0_lane    <= 2'd0;
            x1_lane    <= 2'd3;
            y_cur      <= '0;
            y_last     <= '0;
            clearing   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        rgb_q   <= req_rgb;
                        first_w <= req_x[7:2];
                        cur_w   <= req_x[7:2];
                        burst_w <= req_x[7:2];
                        x0_lane <= req_x[1:0];
                        last_w  <= x1_c[7:2];
                        x1_lane <= x1_c[1:0];
                        y_cur   <= req_y;
                        y_last  <= y1_c;
                    end
                end
                CLEAR_INIT: begin
                    if (calib_done) begin
                        rgb_q    <= 8'h00;
                        first_w  <= '0;
                        cur_w    <= '0;
                        burst_w  <= '0;
                        x0_lane  <= 2'd0;
                        last_w   <= X_MAX[7:2];
                        x1_lane  <= X_MAX[1:0];
                        y_cur    <= '0;
                        y_last   <= Y_MAX[COORD_W-1:0];
                        clearing <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (mem_wr_en && !burst_end_c) begin
                        cur_w <= cur_w + WORD_W'(1);
                    end
                end
                NEXT: begin
                    if (calib_done) begin
                        if (!row_done_c) begin
                            cur_w   <= cur_w + WORD_W'(1);
                            burst_w <= cur_w + WORD_W'(1);
                        end else if (!last_row_c) begin
                            y_cur   <= y_cur + COORD_W'(1);
                            cur_w   <= first_w;
                            burst_w <= first_w;
                        end else if (clearing) begin
                            clearing   <= 1'b0;
                            clear_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_writer.sv
// Directed bench for rect_writer: startup clear, pixel, rectangles, clipping, stalls and reset.
module tb_rect_writer;

    localparam logic [13:0] P = 14'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        calib_done;
    logic        clear_done;
    logic        ready;
    logic        req_en, req_fill;
    logic [7:0]  req_rgb, req_x, req_y, req_w, req_h;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    logic [35:0] wr_q[$];
    logic [35:0] cmd_q[$];

    rect_writer dut (
        .clk(clk), .rst(rst), .calib_done(calib_done), .clear_done(clear_done), .ready(ready),
        .req_en(req_en), .req_fill(req_fill), .req_rgb(req_rgb), .req_x(req_x), .req_y(req_y),
        .req_w(req_w), .req_h(req_h),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
        .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
        .mem_wr_full(mem_wr_full)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: records accepted transfers and protocol violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_en)  wr_q.push_back({mem_wr_mask, mem_wr_data});
            if (mem_cmd_en) cmd_q.push_back({mem_cmd_bl, mem_cmd_byte_addr});
            if (mem_wr_en && mem_cmd_en) viol++;
            if (mem_wr_en && (mem_wr_full || !calib_done)) viol++;
            if (mem_cmd_en && (mem_cmd_full || !calib_done)) viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int n = 0;
        while (!clear_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, clear_done, 1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, ready, 1);
    endtask

    task automatic issue(input logic fill, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] w, input logic [7:0] h, input logic [7:0] rgb);
        @(posedge clk); #1;
        req_en = 1'b1; req_fill = fill; req_x = x; req_y = y; req_w = w; req_h = h; req_rgb = rgb;
        @(negedge clk);
        check("accept_ready", ready, 1);
        @(posedge clk); #1;
        req_en = 1'b0;
    endtask

    task automatic check_clear(input string tag, input int wbase, input int cbase);
        int bad_w = 0;
        int bad_c = 0;
        logic [35:0] e;
        check({tag, "_words"}, wr_q.size() - wbase, 12288);
        check({tag, "_cmds"}, cmd_q.size() - cbase, 384);
        for (int i = wbase; i < wr_q.size(); i++)
            if (wr_q[i] !== 36'h0) bad_w++;
        for (int i = cbase; i < cmd_q.size(); i++) begin
            e = {6'd31, P, 8'((i - cbase) / 2), (((i - cbase) % 2) != 0) ? 8'h80 : 8'h00};
            if (cmd_q[i] !== e) bad_c++;
        end
        check({tag, "_word_vals"}, bad_w, 0);
        check({tag, "_cmd_vals"}, bad_c, 0);
    endtask

    initial begin
        int wb, cb, w0, n, bad;

        rst = 1'b1; calib_done = 1'b0; req_en = 1'b0; req_fill = 1'b0;
        req_rgb = 8'h00; req_x = 8'h00; req_y = 8'h00; req_w = 8'h00; req_h = 8'h00;
        mem_cmd_full = 1'b0; mem_wr_full = 1'b0;
        cycles(3);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_cmd_en", mem_cmd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_bl", mem_cmd_bl, 0);
        check("rst_mask", mem_wr_mask, 0);
        check("rst_data", mem_wr_data, 0);
        check("rst_addr", mem_cmd_byte_addr, {P, 16'h0});
        check("instr", mem_cmd_instr, 3'b000);

        // Calibration not yet done: the clear must wait.
        @(posedge clk); #1; rst = 1'b0;
        cycles(5);
        check("precal_words", wr_q.size(), 0);
        check("precal_clear_done", clear_done, 0);

        // Startup clear, with a calibration drop part way through.
        wb = wr_q.size(); cb = cmd_q.size();
        calib_done = 1'b1;
        n = 0;
        while (wr_q.size() < wb + 100 && n < 1000) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1; calib_done = 1'b0;
        w0 = wr_q.size();
        cycles(8);
        check("caldrop_hold", wr_q.size(), w0);
        calib_done = 1'b1;
        wait_clear("clear_timeout", 20000);
        check("clear_cmds_before_done", cmd_q.size() - cb, 384);
        check_clear("clear", wb, cb);
        wait_ready("clear_ready", 10);
        check("viol_clear", viol, 0);

        // Single pixel with exact latency.
        wb = wr_q.size(); cb = cmd_q.size();
        issue(1'b0, 8'd53, 8'd50, 8'd0, 8'd0, 8'hFF);
        @(negedge clk);
        check("px_wr_en", mem_wr_en, 1);
        check("px_data", mem_wr_data, 32'hFFFFFFFF);
        check("px_mask", mem_wr_mask, 4'b1101);
        @(negedge clk);
        check("px_cmd_en", mem_cmd_en, 1);
        check("px_bl", mem_cmd_bl, 0);
        check("px_addr", mem_cmd_byte_addr, {P, 8'd50, 6'd13, 2'b00});
        @(negedge clk);
        check("px_ready_t3", ready, 0);
        @(negedge clk);
        check("px_ready_t4", ready, 1);
        check("px_nwords", wr_q.size() - wb, 1);
        check("px_ncmds", cmd_q.size() - cb, 1);

        // Two-row rectangle with a left-edge mask.
        wb = wr_q.size(); cb = cmd_q.size();
        issue(1'b1, 8'd2, 8'd10, 8'd5, 8'd1, 8'h1C);
        wait_ready("rect_ready", 100);
        check("rect_nwords", wr_q.size() - wb, 4);
        check("rect_ncmds", cmd_q.size() - cb, 2);
        if (wr_q.size() - wb == 4 && cmd_q.size() - cb == 2) begin
            check("rect_w0", wr_q[wb],     {4'b0011, 32'h1C1C1C1C});
            check("rect_w1", wr_q[wb + 1], {4'b0000, 32'h1C1C1C1C});
            check("rect_w2", wr_q[wb + 2], {4'b0011, 32'h1C1C1C1C});
            check("rect_w3", wr_q[wb + 3], {4'b0000, 32'h1C1C1C1C});
            check("rect_c0", cmd_q[cb],     {6'd1, P, 8'd10, 8'h00});
            check("rect_c1", cmd_q[cb + 1], {6'd1, P, 8'd11, 8'h00});
        end

        // Clipped at the bottom-right corner.
        wb = wr_q.size(); cb = cmd_q.size();
        issue(1'b1, 8'd250, 8'd191, 8'd20, 8'd5, 8'hE0);
        wait_ready("clip_ready", 100);
        check("clip_nwords", wr_q.size() - wb, 2);
        check("clip_ncmds", cmd_q.size() - cb, 1);
        if (wr_q.size() - wb == 2 && cmd_q.size() - cb == 1) begin
            check("clip_w0", wr_q[wb],     {4'b0011, 32'hE0E0E0E0});
            check("clip_w1", wr_q[wb + 1], {4'b0000, 32'hE0E0E0E0});
            check("clip_c0", cmd_q[cb],    {6'd1, P, 8'd191, 6'd62, 2'b00});
        end

        // Narrow rectangle inside one word: both edge masks combine.
        wb = wr_q.size(); cb = cmd_q.size();
        issue(1'b1, 8'd5, 8'd3, 8'd1, 8'd0, 8'h55);
        wait_ready("narrow_ready", 100);
        check("narrow_nwords", wr_q.size() - wb, 1);
        if (wr_q.size() - wb == 1 && cmd_q.size() - cb == 1) begin
            check("narrow_w0", wr_q[wb],  {4'b1001, 32'h55555555});
            check("narrow_c0", cmd_q[cb], {6'd0, P, 8'd3, 6'd1, 2'b00});
        end

        // Off-screen origin: no traffic, ready again immediately.
        wb = wr_q.size(); cb = cmd_q.size();
        issue(1'b1, 8'd10, 8'd200, 8'd3, 8'd3, 8'h77);
        @(negedge clk);
        check("offscr_ready", ready, 1);
        cycles(5);
        check("offscr_words", wr_q.size() - wb, 0);
        check("offscr_cmds", cmd_q.size() - cb, 0);

        // Full-width row under write and command back-pressure.
        wb = wr_q.size(); cb = cmd_q.size();
        mem_cmd_full = 1'b1;
        issue(1'b1, 8'd0, 8'd20, 8'd255, 8'd0, 8'hA5);
        cycles(5);
        mem_wr_full = 1'b1;
        w0 = wr_q.size();
        cycles(10);
        check("wrfull_hold", wr_q.size(), w0);
        mem_wr_full = 1'b0;
        n = 0;
        while (wr_q.size() < wb + 32 && n < 200) begin
            @(negedge clk); n++;
        end
        cycles(5);
        check("cmdfull_hold", cmd_q.size() - cb, 0);
        mem_cmd_full = 1'b0;
        wait_ready("stall_ready", 300);
        check("stall_nwords", wr_q.size() - wb, 64);
        check("stall_ncmds", cmd_q.size() - cb, 2);
        bad = 0;
        for (int i = wb; i < wr_q.size(); i++)
            if (wr_q[i] !== {4'b0000, 32'hA5A5A5A5}) bad++;
        check("stall_word_vals", bad, 0);
        if (cmd_q.size() - cb == 2) begin
            check("stall_c0", cmd_q[cb],     {6'd31, P, 8'd20, 8'h00});
            check("stall_c1", cmd_q[cb + 1], {6'd31, P, 8'd20, 8'h80});
        end
        check("viol_stall", viol, 0);

        // Reset in the middle of a large fill, then the clear reruns.
        issue(1'b1, 8'd0, 8'd0, 8'd255, 8'd100, 8'h3C);
        cycles(20);
        #2 rst = 1'b1;
        #1;
        check("mrst_wr_en", mem_wr_en, 0);
        check("mrst_cmd_en", mem_cmd_en, 0);
        check("mrst_clear_done", clear_done, 0);
        check("mrst_ready", ready, 0);
        check("mrst_mask", mem_wr_mask, 0);
        check("mrst_data", mem_wr_data, 0);
        check("mrst_bl", mem_cmd_bl, 0);
        check("mrst_addr", mem_cmd_byte_addr, {P, 16'h0});
        @(posedge clk); #1;
        wb = wr_q.size(); cb = cmd_q.size();
        rst = 1'b0;
        wait_clear("reclear_timeout", 20000);
        check_clear("reclear", wb, cb);
        wait_ready("reclear_ready", 10);
        check("viol_final", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
